// File: rtl/dense_argmax_reader.sv
// rtl/dense_argmax_reader.sv - snapshots dense-layer logits on start and scans them for the argmax.
// Optional macro ARGMAX_SECOND_EN adds a runner-up (second_idx/second_val) result.
module dense_argmax_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 7,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] in_vec [0:NUM_CLASSES-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_idx,
    output logic signed [DATA_WIDTH-1:0] out_val,
    output logic                         busy,
    output logic                         overrun
`ifdef ARGMAX_SECOND_EN
    ,
    output logic [IDX_W-1:0]             second_idx,
    output logic signed [DATA_WIDTH-1:0] second_val
`endif
);

    if (NUM_CLASSES < 1 || FRAC_BITS >= DATA_WIDTH) begin : g_bad_cfg
        $error("dense_argmax_reader: invalid NUM_CLASSES/FRAC_BITS");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);
    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                  state_q, state_d;
    logic signed [DATA_WIDTH-1:0] snap_q [0:NUM_CLASSES-1];
    logic [IDX_W-1:0]            i_q, i_d;
    logic signed [DATA_WIDTH-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]            best_idx_q, best_idx_d;
    logic                        out_valid_q, out_valid_d;
    logic [IDX_W-1:0]            out_idx_q, out_idx_d;
    logic signed [DATA_WIDTH-1:0] out_val_q, out_val_d;
    logic                        busy_q, busy_d;
    logic                        overrun_q, overrun_d;
    logic                        transfer, accept;
    logic signed [DATA_WIDTH-1:0] cur;
    logic signed [DATA_WIDTH-1:0] cmp_val;
    logic [IDX_W-1:0]            cmp_idx;
    logic                        new_best;

    assign transfer = (state_q == HOLD) && out_valid_q && out_ready;
    // A start coinciding with a hand-off is treated exactly like an IDLE start.
    assign accept   = start && ((state_q == IDLE) || transfer);
    assign cur      = snap_q[i_q];
    assign new_best = cur > best_val_q;
    assign cmp_val  = new_best ? cur : best_val_q;
    assign cmp_idx  = new_best ? i_q : best_idx_q;

`ifdef ARGMAX_SECOND_EN
    logic signed [DATA_WIDTH-1:0] sec_val_q, sec_val_d, sec_out_val_q, sec_out_val_d;
    logic [IDX_W-1:0]            sec_idx_q, sec_idx_d, sec_out_idx_q, sec_out_idx_d;
    logic                        sec_set_q, sec_set_d;
    logic signed [DATA_WIDTH-1:0] sec_cmp_val;
    logic [IDX_W-1:0]            sec_cmp_idx;

    // A dethroned best becomes the runner-up; otherwise cur competes for second place.
    always_comb begin
        sec_cmp_val = sec_val_q;
        sec_cmp_idx = sec_idx_q;
        if (new_best) begin
            sec_cmp_val = best_val_q;
            sec_cmp_idx = best_idx_q;
        end else if (!sec_set_q || cur > sec_val_q) begin
            sec_cmp_val = cur;
            sec_cmp_idx = i_q;
        end
    end

    always_comb begin
        sec_val_d     = sec_val_q;
        sec_idx_d     = sec_idx_q;
        sec_set_d     = sec_set_q;
        sec_out_val_d = sec_out_val_q;
        sec_out_idx_d = sec_out_idx_q;
        if (state_q == SCAN) begin
            sec_val_d = sec_cmp_val;
            sec_idx_d = sec_cmp_idx;
            sec_set_d = 1'b1;
            if (i_q == LAST) begin
                sec_out_val_d = sec_cmp_val;
                sec_out_idx_d = sec_cmp_idx;
            end
        end
        if (accept) begin
            sec_val_d = MOST_NEG;
            sec_idx_d = '0;
            sec_set_d = 1'b0;
            if (NUM_CLASSES == 1) begin
                sec_out_val_d = MOST_NEG;
                sec_out_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sec_val_q     <= '0;
            sec_idx_q     <= '0;
            sec_set_q     <= 1'b0;
            sec_out_val_q <= '0;
            sec_out_idx_q <= '0;
        end else begin
            sec_val_q     <= sec_val_d;
            sec_idx_q     <= sec_idx_d;
            sec_set_q     <= sec_set_d;
            sec_out_val_q <= sec_out_val_d;
            sec_out_idx_q <= sec_out_idx_d;
        end
    end

    assign second_idx = sec_out_idx_q;
    assign second_val = sec_out_val_q;
`endif

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_val_d   = out_val_q;
        case (state_q)
            SCAN: begin
                best_val_d = cmp_val;
                best_idx_d = cmp_idx;
                if (i_q == LAST) begin
                    state_d   = HOLD;
                    out_idx_d = cmp_idx;
                    out_val_d = cmp_val;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            HOLD: begin
                if (transfer) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (accept) begin
            best_val_d = in_vec[0];
            best_idx_d = '0;
            if (NUM_CLASSES == 1) begin
                state_d   = HOLD;
                i_d       = '0;
                out_idx_d = '0;
                out_val_d = in_vec[0];
            end else begin
                state_d = SCAN;
                i_d     = IDX_W'(1);
            end
        end
        overrun_d = start && !accept;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            i_q         <= '0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_val_q   <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) snap_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_val_q   <= out_val_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            if (accept) begin
                for (int k = 0; k < NUM_CLASSES; k++) snap_q[k] <= in_vec[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_val   = out_val_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_dense_argmax_reader.sv
// tb/tb_dense_argmax_reader.sv - directed and random checks of dense_argmax_reader against an argmax model.
module tb_dense_argmax_reader;
    localparam int DW = 16;
    localparam int N  = 10;
    localparam int IW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, out_ready;
    logic signed [DW-1:0] in_vec [0:N-1];
    logic out_valid, busy, overrun;
    logic [IW-1:0] out_idx;
    logic signed [DW-1:0] out_val;
`ifdef ARGMAX_SECOND_EN
    logic [IW-1:0] second_idx;
    logic signed [DW-1:0] second_val;
`endif

    dense_argmax_reader #(.DATA_WIDTH(DW), .FRAC_BITS(7), .NUM_CLASSES(N)) dut (
        .clk(clk), .reset(reset), .start(start), .in_vec(in_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_val(out_val),
        .busy(busy), .overrun(overrun)
`ifdef ARGMAX_SECOND_EN
        , .second_idx(second_idx), .second_val(second_val)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    logic signed [DW-1:0] vec [0:N-1];
    int exp_idx, exp_val, exp_sidx, exp_sval;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: first index holding the maximum; runner-up is the best of the rest, lowest index on ties.
    task automatic model();
        exp_idx = 0;
        for (int k = 1; k < N; k++) if (vec[k] > vec[exp_idx]) exp_idx = k;
        exp_val  = vec[exp_idx];
        exp_sidx = -1;
        for (int k = 0; k < N; k++)
            if (k != exp_idx && (exp_sidx < 0 || vec[k] > vec[exp_sidx])) exp_sidx = k;
        exp_sval = vec[exp_sidx];
    endtask

    task automatic drive_vec();
        for (int k = 0; k < N; k++) in_vec[k] = vec[k];
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, N);
        chk({tag, "_idx"}, out_idx, exp_idx);
        chk({tag, "_val"}, out_val, exp_val);
`ifdef ARGMAX_SECOND_EN
        chk({tag, "_sidx"}, second_idx, exp_sidx);
        chk({tag, "_sval"}, second_val, exp_sval);
`endif
    endtask

    task automatic launch(input string tag);
        model();
        drive_vec();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_result(tag);
    endtask

    task automatic rand_vec(input bit narrow);
        int r;
        for (int k = 0; k < N; k++) begin
            r = narrow ? ($urandom_range(0, 3) - 2) : int'($urandom());
            vec[k] = r[DW-1:0];
        end
    endtask

    initial begin
        int ovr, h_idx, h_val, stable;
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < N; k++) in_vec[k] = '0;
        step(); step();
        chk("rst_valid", out_valid, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_val", out_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
`ifdef ARGMAX_SECOND_EN
        chk("rst_sidx", second_idx, 0);
        chk("rst_sval", second_val, 0);
`endif
        reset = 1'b0;
        step();

        vec = '{16'sd5, -16'sd3, 16'sd100, 16'sd7, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd128};
        launch("basic");
        chk("basic_idx_abs", out_idx, 2);
        chk("basic_val_abs", out_val, 100);
        step();
        chk("basic_onecycle", out_valid, 0);
        chk("basic_busy_after", busy, 0);

        for (int k = 0; k < N; k++) vec[k] = -16'sd32768;
        launch("allneg");
        chk("allneg_idx_abs", out_idx, 0);
        chk("allneg_val_abs", out_val, -32768);
        step();

        vec = '{16'sd0, 16'sd9, 16'sd9, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        launch("tie");
        chk("tie_idx_abs", out_idx, 1);
        step();

        // Stall in HOLD with a dropped start and changing inputs.
        out_ready = 1'b0;
        rand_vec(1'b0);
        launch("stall");
        h_idx = exp_idx; h_val = exp_val; ovr = 0; stable = 1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                rand_vec(1'b0);
                drive_vec();
                start = 1'b1;
            end
            step();
            start = 1'b0;
            if (overrun) ovr++;
            if (!out_valid || out_idx != h_idx[IW-1:0] || out_val != h_val[DW-1:0]) stable = 0;
        end
        chk("stall_overrun_pulses", ovr, 1);
        chk("stall_stable", stable, 1);
        chk("stall_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        chk("stall_xfer_valid", out_valid, 0);
        step();
        chk("stall_single_xfer", out_valid, 0);
        chk("stall_busy", busy, 0);

        // Start in the same cycle as the hand-off.
        out_ready = 1'b0;
        rand_vec(1'b0);
        launch("b2b_first");
        rand_vec(1'b0);
        for (int k = 0; k < N - 1; k++) if (vec[k] == 16'sh7fff) vec[k] = 16'sd0;
        vec[N-1] = 16'sh7fff;
        model();
        drive_vec();
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_overrun", overrun, 0);
        chk("b2b_valid_drop", out_valid, 0);
        chk("b2b_busy", busy, 1);
        wait_result("b2b_second");
        chk("b2b_idx_abs", out_idx, 9);
        step();

        // Reset in the middle of a scan, with a start racing it.
        rand_vec(1'b0);
        drive_vec();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        start = 1'b1;
        step();
        chk("rstscan_valid", out_valid, 0);
        chk("rstscan_busy", busy, 0);
        chk("rstscan_overrun", overrun, 0);
        reset = 1'b0;
        start = 1'b0;
        step();
        chk("rstscan_idle_busy", busy, 0);
        rand_vec(1'b0);
        launch("after_reset");
        step();

`ifdef ARGMAX_SECOND_EN
        vec = '{16'sd3, 16'sd8, 16'sd8, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        launch("sec_a");
        chk("sec_a_sidx_abs", second_idx, 2);
        chk("sec_a_sval_abs", second_val, 8);
        step();
        vec[0] = 16'sd10;
        for (int k = 1; k < N; k++) vec[k] = -16'sd5;
        launch("sec_b");
        chk("sec_b_sidx_abs", second_idx, 1);
        chk("sec_b_sval_abs", second_val, -5);
        step();
`endif

        for (int t = 0; t < 12; t++) begin
            rand_vec(t[0]);
            launch($sformatf("rand%0d", t));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dense_argmax_reader.md
Name: dense_argmax_reader

Overview:
Consumer at the output end of the dense layer. On the dense layer's one-cycle completion pulse it snapshots the OUT_DIM signed fixed-point logits and scans them sequentially, one element per cycle, for the maximum. It then presents the winning class index and value on a valid/ready result port. It is the final classification stage before result reporting (LEDs/UART), and it decouples the downstream reader from the dense layer restarting.

Parameters:
DATA_WIDTH, 16, logit width, signed two's complement, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
FRAC_BITS, 7, fractional bits; informational only, comparisons are on raw signed values
NUM_CLASSES, 10, number of logits; must be >= 1
IDX_W, $clog2(NUM_CLASSES) (minimum 1), class index width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
start  input  1  one-cycle pulse, driven by the dense layer's done
in_vec  input  DATA_WIDTH x [0:NUM_CLASSES-1]  signed logits, sampled only on an accepted start
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_idx  output  IDX_W  index of the maximum logit
out_val  output  DATA_WIDTH  signed maximum logit value
busy  output  1  high in SCAN and HOLD
overrun  output  1  one-cycle pulse: start arrived and was dropped

Behaviour:
- Reset (clk, reset: synchronous, active-high):
  - state=IDLE; out_valid=0, out_idx=0, out_val=0, busy=0, overrun=0.
  - Snapshot and scan registers cleared.
  - Reset mid-SCAN or mid-HOLD aborts; no result is produced.
- States: IDLE, SCAN, HOLD.
- IDLE, start=1 (accepted start edge, E0):
  - snap[k] <= in_vec[k] for all k.
  - best_val <= in_vec[0], best_idx <= 0, i <= 1.
  - Next state: SCAN, or HOLD directly if NUM_CLASSES==1.
- SCAN, one element per cycle:
  - If snap[i] > best_val (signed, strict), update best_val and best_idx <= i.
  - On i == NUM_CLASSES-1: go to HOLD, with out_idx/out_val loaded from the final comparison result. Otherwise i <= i+1.
- Ties: the lowest index wins, by the strict > comparison.
- Latency: out_valid rises after edge E0+NUM_CLASSES (E0+10 at default). For NUM_CLASSES==1 it rises after E0+1.
- HOLD:
  - out_valid=1; out_idx and out_val held stable until the transfer.
  - Transfer occurs on an edge with out_valid && out_ready; next state IDLE and out_valid drops.
  - out_ready is ignored when out_valid=0.
- Back-to-back: start in the same cycle as a HOLD transfer is accepted, as an IDLE start would be. The snapshot is taken that edge, next state is SCAN, and out_valid deasserts for at least NUM_CLASSES-1 cycles (NUM_CLASSES>1).
- Dropped start: start in SCAN, or in HOLD without a transfer, is ignored.
  - overrun pulses high for exactly the following cycle.
  - snap, in-progress scan and held result are untouched.
- busy = (state != IDLE), registered with state.
- in_vec may change freely after the start edge; only snap is used.
- No arithmetic beyond signed compare; full DATA_WIDTH range is legal, including the most negative value.

Optional Feature:
- Macro: ARGMAX_SECOND_EN.
- Defined:
  - Extra outputs second_idx [IDX_W] and second_val [DATA_WIDTH] (reset 0), held and valid with out_valid.
  - On a new strict maximum, the old best is demoted to second.
  - Otherwise, if snap[i] > second_val, or second is not yet set, snap[i] becomes second.
  - Ties resolve to the lower index.
  - For NUM_CLASSES==1, second_idx=0 and second_val = most negative value.
  - Latency is unchanged.
- Undefined: ports and logic absent; behaviour identical otherwise.

Test Plan:
- Reset, then logits {5,-3,100,7,0,0,0,0,0,-128}, start pulse, out_ready=1 -> out_valid after exactly 10 edges, out_idx=2, out_val=100, one-cycle valid, busy low afterwards.
- All logits = -32768 -> out_idx=0, out_val=-32768. Tie test {0,9,9,...} -> out_idx=1.
- out_ready=0 for 20 cycles after valid; in_vec changed and a second start issued during HOLD -> result stable, overrun pulses once, out_valid stays high; ready=1 -> single transfer.
- Start asserted in the same cycle as the transfer, with new logits max at index 9 -> accepted, no overrun, next result out_idx=9 after 10 edges.
- Reset asserted mid-SCAN (edge E0+4) -> out_valid, busy and overrun 0 next cycle; a following start scans cleanly.
- ARGMAX_SECOND_EN build, {3,8,8,1,...} -> out_idx=1/8, second_idx=2/8. {10,-5,...all -5} -> second_idx=1, second_val=-5.
